cpu_control: RTL and testbench
==============================

# cpu_control

Multicycle controller that sequences `cpu_datapath`. It is a Moore FSM that fetches each instruction, decodes `instr[4:0]`, and drives every mux select and register write-enable of the datapath. It also drives a single-port memory read/write handshake that tolerates wait states. It sits beside the datapath in the CPU top; both share `clk` and `reset`.

## Interface
- Parameters: none.
- `clk`  in  1  rising-edge clock, shared with the datapath.
- `reset`  in  1  synchronous, active-high reset.
- `instr`  in  5  `ir[4:0]` from the datapath.
  - `[3:0]` is the opcode.
  - `[4]` is the immediate flag.
- `flag_n`, `flag_z`  in  1 each  registered ALU flags.
- `mem_ready`  in  1  memory completes the pending access at this edge.
- `alu_1`  out  1  ALU A source: 0 = pc, 1 = opA.
- `alu_2`  out  2  ALU B source: 0 = opB, 1 = sext(ir[15:8]), 2 = sext(ir[15:5]), 3 = constant 1.
- `ALU_op`  out  1  0 = add, 1 = subtract.
- `reg_in`  out  3  RF write data: 0 = ALU_out, 1 = mdr, 2 = opB, 3 = sext(ir[15:8]), 4 = pc.
- `addr_sel`  out  1  memory address: 0 = pc, 1 = opB.
- `pc_sel`  out  1  PC source: 0 = ALU_out_wire, 1 = opA.
- `reg_w_sel`  out  1  write register: 0 = ir[7:5], 1 = r7.
- `opA_wr`, `opB_wr`, `alu_out_wr`, `PC_wr`, `MDR_wr`, `ir_wr`, `flag_wr`, `RF_wr`  out  1 each  datapath write enables.
- `mem_rd`, `mem_wr`  out  1 each  memory access request.
- `halted`  out  1  high while in HALT.

## Operation
- **States:** FETCH, DECODE, EXEC, MEM, WB, HALT.
- **Default outputs:** every output is 0 unless listed for the current state and opcode.
- **Opcodes** (`instr[3:0]`), with `rx` = ir[7:5] and `ry` = ir[10:8]:
  - 0 MV
  - 1 ADD
  - 2 SUB
  - 3 CMP
  - 4 LD rx,[ry]
  - 5 ST rx,[ry]
  - 8 J
  - 9 JZ
  - 10 JN
  - 12 CALL
  - 15 HALT
  - All other opcodes execute as NOP.
- **FETCH:** `mem_rd`=1, `addr_sel`=0.
  - Holds until `mem_ready`.
  - In the `mem_ready` cycle: `ir_wr`=1, and `PC_wr`=1 with `alu_1`=0, `alu_2`=3, `pc_sel`=0 (pc <= pc+1).
  - Then go to DECODE.
- **DECODE:** `opA_wr`=`opB_wr`=1.
  - Opcode 15 → HALT.
  - LD/ST → MEM.
  - NOP → FETCH.
  - All others → EXEC.
- **EXEC, MV:** `RF_wr`=1, `reg_w_sel`=0; `reg_in`=3 if `instr[4]`, else 2. Then → FETCH.
- **EXEC, ADD/SUB/CMP:**
  - `alu_1`=1; `alu_2`=1 if `instr[4]`, else 0.
  - `ALU_op`=1 for SUB and CMP.
  - `alu_out_wr`=1, `flag_wr`=1.
  - ADD/SUB → WB; CMP → FETCH.
- **EXEC, jumps (J/JZ/JN):**
  - Taken condition: J always; JZ when `flag_z`; JN when `flag_n`.
  - If taken, `PC_wr`=1 with either:
    - `instr[4]`=1: `alu_1`=0, `alu_2`=2, `pc_sel`=0 (target = pc+1+imm11);
    - `instr[4]`=0: `pc_sel`=1 (target = opA).
  - Then → FETCH.
- **EXEC, CALL:** as an unconditional jump, plus `RF_wr`=1, `reg_in`=4, `reg_w_sel`=1.
  - r7 receives the already-incremented pc in the same edge that pc is overwritten.
  - Then → FETCH.
- **MEM:** `addr_sel`=1; `mem_rd`=1 for LD, `mem_wr`=1 for ST (data is opA).
  - Holds until `mem_ready`.
  - LD: `MDR_wr`=1 in the ready cycle, then → WB.
  - ST: → FETCH.
- **WB:** `RF_wr`=1, `reg_w_sel`=0; `reg_in`=1 for LD, 0 otherwise. Then → FETCH.
- **HALT:** `halted`=1, all enables 0; stays in HALT until `reset`.

## Timing
- **Reset:** while `reset`=1 at an edge, the next state is FETCH.
  - While `reset` is high, all outputs are forced to 0, including `mem_rd`.
  - The first cycle after release is FETCH with `mem_rd`=1.
- **Mid-access reset:** reset during FETCH or MEM abandons the access; requests drop the next cycle with no write enables.
- **Handshake:**
  - A request (`mem_rd`/`mem_wr`) and its address select stay stable until `mem_ready` is sampled high.
  - `mem_ready` is ignored outside FETCH and MEM.
  - There is no timeout.
- **Cycle counts with zero-wait memory:**
  - ALU op: 4
  - CMP, MV, jumps, CALL: 3
  - LD: 4
  - ST: 3
  - Each wait cycle adds 1.
- **Decode timing:** `instr` is valid from DECODE onward. Flags sampled in EXEC reflect the last completed `flag_wr`.

## Test plan
- Reset, ADD r1,r2 (`instr`=5'b00001), `mem_ready`=1 → per-cycle outputs:
  - cycle 1: `ir_wr` and `PC_wr` with `alu_2`=3;
  - cycle 2: `opA_wr` and `opB_wr`;
  - cycle 3: `alu_out_wr`, `flag_wr`, `ALU_op`=0;
  - cycle 4: `RF_wr` with `reg_in`=0.
- LD (5'b00100) with `mem_ready` low for 3 MEM cycles → `mem_rd`=1 and `addr_sel`=1 held 4 cycles; `MDR_wr` only in the 4th; then WB with `reg_in`=1.
- JZ imm (5'b11001):
  - `flag_z`=0 → EXEC has no `PC_wr`;
  - `flag_z`=1 → `PC_wr`=1, `alu_1`=0, `alu_2`=2, `pc_sel`=0.
- CALL reg (5'b01100) → EXEC: `RF_wr`=1, `reg_in`=4, `reg_w_sel`=1, `PC_wr`=1, `pc_sel`=1.
- HALT (5'b01111) → `halted`=1 and all enables 0 for 20+ cycles; `reset` pulse → FETCH with `mem_rd`=1.
- ST with `mem_ready`=0 and `reset` asserted in MEM → next cycle `mem_wr`=0, all enables 0; after release, FETCH.

Source files
------------

// File: rtl/cpu_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_control : multicycle Moore controller sequencing cpu_datapath    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cpu_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] instr,
    input  logic       flag_n,
    input  logic       flag_z,
    input  logic       mem_ready,
    output logic       alu_1,
    output logic [1:0] alu_2,
    output logic       ALU_op,
    output logic [2:0] reg_in,
    output logic       addr_sel,
    output logic       pc_sel,
    output logic       reg_w_sel,
    output logic       opA_wr,
    output logic       opB_wr,
    output logic       alu_out_wr,
    output logic       PC_wr,
    output logic       MDR_wr,
    output logic       ir_wr,
    output logic       flag_wr,
    output logic       RF_wr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] c_OP_MV   = 4'd0;
    localparam logic [3:0] c_OP_ADD  = 4'd1;
    localparam logic [3:0] c_OP_SUB  = 4'd2;
    localparam logic [3:0] c_OP_CMP  = 4'd3;
    localparam logic [3:0] c_OP_LD   = 4'd4;
    localparam logic [3:0] c_OP_ST   = 4'd5;
    localparam logic [3:0] c_OP_J    = 4'd8;
    localparam logic [3:0] c_OP_JZ   = 4'd9;
    localparam logic [3:0] c_OP_JN   = 4'd10;
    localparam logic [3:0] c_OP_CALL = 4'd12;
    localparam logic [3:0] c_OP_HALT = 4'd15;

    state_t     state_q, state_d;
    logic [3:0] w_op;
    logic       w_imm;
    logic       w_taken;

    assign w_op    = instr[3:0];
    assign w_imm   = instr[4];
    assign w_taken = (w_op == c_OP_J) || (w_op == c_OP_CALL) ||
                     ((w_op == c_OP_JZ) && flag_z) ||
                     ((w_op == c_OP_JN) && flag_n);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    c_OP_HALT:                 state_d = S_HALT;
                    c_OP_LD, c_OP_ST:          state_d = S_MEM;
                    c_OP_MV, c_OP_ADD, c_OP_SUB, c_OP_CMP,
                    c_OP_J, c_OP_JZ, c_OP_JN, c_OP_CALL:
                                               state_d = S_EXEC;
                    default:                   state_d = S_FETCH;
                endcase
            end
            S_EXEC:   state_d = ((w_op == c_OP_ADD) || (w_op == c_OP_SUB)) ? S_WB : S_FETCH;
            S_MEM:    if (mem_ready) state_d = (w_op == c_OP_LD) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Reset masks every output immediately so a pending access is dropped.
    always_comb begin
        alu_1      = 1'b0;
        alu_2      = 2'd0;
        ALU_op     = 1'b0;
        reg_in     = 3'd0;
        addr_sel   = 1'b0;
        pc_sel     = 1'b0;
        reg_w_sel  = 1'b0;
        opA_wr     = 1'b0;
        opB_wr     = 1'b0;
        alu_out_wr = 1'b0;
        PC_wr      = 1'b0;
        MDR_wr     = 1'b0;
        ir_wr      = 1'b0;
        flag_wr    = 1'b0;
        RF_wr      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        halted     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        ir_wr = 1'b1;
                        PC_wr = 1'b1;
                        alu_2 = 2'd3;
                    end
                end
                S_DECODE: begin
                    opA_wr = 1'b1;
                    opB_wr = 1'b1;
                end
                S_EXEC: begin
                    case (w_op)
                        c_OP_MV: begin
                            RF_wr  = 1'b1;
                            reg_in = w_imm ? 3'd3 : 3'd2;
                        end
                        c_OP_ADD, c_OP_SUB, c_OP_CMP: begin
                            alu_1      = 1'b1;
                            alu_2      = w_imm ? 2'd1 : 2'd0;
                            ALU_op     = (w_op != c_OP_ADD);
                            alu_out_wr = 1'b1;
                            flag_wr    = 1'b1;
                        end
                        c_OP_J, c_OP_JZ, c_OP_JN, c_OP_CALL: begin
                            if (w_taken) begin
                                PC_wr = 1'b1;
                                if (w_imm) alu_2  = 2'd2;
                                else       pc_sel = 1'b1;
                            end
                            // r7 captures the pc already advanced during FETCH.
                            if (w_op == c_OP_CALL) begin
                                RF_wr     = 1'b1;
                                reg_in    = 3'd4;
                                reg_w_sel = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    addr_sel = 1'b1;
                    if (w_op == c_OP_LD) begin
                        mem_rd = 1'b1;
                        MDR_wr = mem_ready;
                    end else begin
                        mem_wr = 1'b1;
                    end
                end
                S_WB: begin
                    RF_wr  = 1'b1;
                    reg_in = (w_op == c_OP_LD) ? 3'd1 : 3'd0;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpu_control : vector table plus randomized instruction stream     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cpu_control;

    typedef struct packed {
        logic        alu_1;
        logic [1:0]  alu_2;
        logic        alu_op;
        logic [2:0]  reg_in;
        logic        addr_sel;
        logic        pc_sel;
        logic        reg_w_sel;
        logic [10:0] en;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [4:0] ins;
        logic       fz;
        logic       fn;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    // enable vector order: opA opB aluout PC MDR ir flag RF rd wr halted
    localparam logic [10:0] E_OPA  = 11'h400;
    localparam logic [10:0] E_OPB  = 11'h200;
    localparam logic [10:0] E_ALUO = 11'h100;
    localparam logic [10:0] E_PC   = 11'h080;
    localparam logic [10:0] E_MDR  = 11'h040;
    localparam logic [10:0] E_IR   = 11'h020;
    localparam logic [10:0] E_FLG  = 11'h010;
    localparam logic [10:0] E_RF   = 11'h008;
    localparam logic [10:0] E_RD   = 11'h004;
    localparam logic [10:0] E_WR   = 11'h002;
    localparam logic [10:0] E_HLT  = 11'h001;

    logic       clk = 1'b0;
    logic       reset, flag_n, flag_z, mem_ready;
    logic [4:0] instr;
    logic       alu_1, ALU_op, addr_sel, pc_sel, reg_w_sel;
    logic [1:0] alu_2;
    logic [2:0] reg_in;
    logic       opA_wr, opB_wr, alu_out_wr, PC_wr, MDR_wr, ir_wr, flag_wr, RF_wr;
    logic       mem_rd, mem_wr, halted;

    int   n_total = 0;
    int   n_bad   = 0;
    int   step    = 0;
    vec_t q[$];
    vec_t tbl[17];

    cpu_control dut (
        .clk(clk), .reset(reset), .instr(instr), .flag_n(flag_n), .flag_z(flag_z),
        .mem_ready(mem_ready), .alu_1(alu_1), .alu_2(alu_2), .ALU_op(ALU_op),
        .reg_in(reg_in), .addr_sel(addr_sel), .pc_sel(pc_sel), .reg_w_sel(reg_w_sel),
        .opA_wr(opA_wr), .opB_wr(opB_wr), .alu_out_wr(alu_out_wr), .PC_wr(PC_wr),
        .MDR_wr(MDR_wr), .ir_wr(ir_wr), .flag_wr(flag_wr), .RF_wr(RF_wr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic outs_t mk(input logic [10:0] en, input logic a1, input logic [1:0] a2,
                                 input logic aop, input logic [2:0] ri, input logic as,
                                 input logic ps, input logic rw);
        outs_t o;
        o.alu_1 = a1; o.alu_2 = a2; o.alu_op = aop; o.reg_in = ri;
        o.addr_sel = as; o.pc_sel = ps; o.reg_w_sel = rw; o.en = en;
        return o;
    endfunction

    function automatic vec_t v(input logic rst, input logic [4:0] ins, input logic fz,
                               input logic fn, input logic rdy, input outs_t exp);
        vec_t r;
        r.rst = rst; r.ins = ins; r.fz = fz; r.fn = fn; r.rdy = rdy; r.exp = exp;
        return r;
    endfunction

    function automatic outs_t fetch_wait();
        return mk(E_RD, 0, 2'd0, 0, 3'd0, 0, 0, 0);
    endfunction

    function automatic outs_t fetch_rdy();
        return mk(E_RD | E_IR | E_PC, 0, 2'd3, 0, 3'd0, 0, 0, 0);
    endfunction

    function automatic outs_t decode_o();
        return mk(E_OPA | E_OPB, 0, 2'd0, 0, 3'd0, 0, 0, 0);
    endfunction

    function automatic logic [4:0] rnd5();
        return 5'($urandom_range(31, 0));
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic void push(input logic rst, input logic [4:0] ins, input logic fz,
                                 input logic fn, input logic rdy, input outs_t exp);
        q.push_back(v(rst, ins, fz, fn, rdy, exp));
    endfunction

    // Reference: expected per-cycle outputs for one whole instruction, built
    // from its phases (fetch with waits, decode, then the opcode's work).
    function automatic void gen_instr(input logic [4:0] ins, input logic fz, input logic fn,
                                      input int w1, input int w2);
        int         op;
        logic       imm;
        logic       taken;
        logic [10:0] en;
        logic [1:0] a2;
        logic       ps;
        op  = int'(ins[3:0]);
        imm = ins[4];
        for (int i = 0; i < w1; i++) push(0, rnd5(), fz, fn, 0, fetch_wait());
        push(0, rnd5(), fz, fn, 1, fetch_rdy());
        push(0, ins, fz, fn, rnd1(), decode_o());
        if (op == 4 || op == 5) begin
            en = (op == 4) ? E_RD : E_WR;
            for (int i = 0; i < w2; i++) push(0, ins, fz, fn, 0, mk(en, 0, 2'd0, 0, 3'd0, 1, 0, 0));
            push(0, ins, fz, fn, 1, mk((op == 4) ? (E_RD | E_MDR) : E_WR, 0, 2'd0, 0, 3'd0, 1, 0, 0));
            if (op == 4) push(0, ins, fz, fn, rnd1(), mk(E_RF, 0, 2'd0, 0, 3'd1, 0, 0, 0));
        end else if (op == 0) begin
            push(0, ins, fz, fn, rnd1(), mk(E_RF, 0, 2'd0, 0, imm ? 3'd3 : 3'd2, 0, 0, 0));
        end else if (op >= 1 && op <= 3) begin
            push(0, ins, fz, fn, rnd1(),
                 mk(E_ALUO | E_FLG, 1, imm ? 2'd1 : 2'd0, (op != 1), 3'd0, 0, 0, 0));
            if (op != 3) push(0, ins, fz, fn, rnd1(), mk(E_RF, 0, 2'd0, 0, 3'd0, 0, 0, 0));
        end else if (op == 8 || op == 9 || op == 10 || op == 12) begin
            taken = (op == 8) || (op == 12) || (op == 9 && fz) || (op == 10 && fn);
            en = 11'h000; a2 = 2'd0; ps = 1'b0;
            if (taken) begin
                en = E_PC;
                if (imm) a2 = 2'd2;
                else     ps = 1'b1;
            end
            if (op == 12) push(0, ins, fz, fn, rnd1(), mk(en | E_RF, 0, a2, 0, 3'd4, 0, ps, 1));
            else          push(0, ins, fz, fn, rnd1(), mk(en, 0, a2, 0, 3'd0, 0, ps, 0));
        end
    endfunction

    task automatic apply(input vec_t x);
        outs_t act;
        reset     = x.rst;
        instr     = x.ins;
        flag_z    = x.fz;
        flag_n    = x.fn;
        mem_ready = x.rdy;
        #2;
        act.alu_1 = alu_1; act.alu_2 = alu_2; act.alu_op = ALU_op; act.reg_in = reg_in;
        act.addr_sel = addr_sel; act.pc_sel = pc_sel; act.reg_w_sel = reg_w_sel;
        act.en = {opA_wr, opB_wr, alu_out_wr, PC_wr, MDR_wr, ir_wr, flag_wr, RF_wr,
                  mem_rd, mem_wr, halted};
        n_total++;
        if (act !== x.exp) begin
            n_bad++;
            $display("FAIL step%0d instr=%b rst=%0d rdy=%0d: outputs got %h want %h",
                     step, x.ins, x.rst, x.rdy, act, x.exp);
        end
        step++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_queue();
        while (q.size() > 0) apply(q.pop_front());
    endtask

    initial begin
        tbl[0]  = v(1, 5'b00001, 0, 0, 0, '0);
        tbl[1]  = v(0, 5'b00001, 0, 0, 1, fetch_rdy());
        tbl[2]  = v(0, 5'b00001, 0, 0, 1, decode_o());
        tbl[3]  = v(0, 5'b00001, 0, 0, 1, mk(E_ALUO | E_FLG, 1, 2'd0, 0, 3'd0, 0, 0, 0));
        tbl[4]  = v(0, 5'b00001, 0, 0, 1, mk(E_RF, 0, 2'd0, 0, 3'd0, 0, 0, 0));
        tbl[5]  = v(0, 5'b11001, 0, 0, 1, fetch_rdy());
        tbl[6]  = v(0, 5'b11001, 0, 0, 1, decode_o());
        tbl[7]  = v(0, 5'b11001, 0, 0, 1, '0);
        tbl[8]  = v(0, 5'b11001, 1, 0, 1, fetch_rdy());
        tbl[9]  = v(0, 5'b11001, 1, 0, 1, decode_o());
        tbl[10] = v(0, 5'b11001, 1, 0, 1, mk(E_PC, 0, 2'd2, 0, 3'd0, 0, 0, 0));
        tbl[11] = v(0, 5'b01100, 0, 0, 1, fetch_rdy());
        tbl[12] = v(0, 5'b01100, 0, 0, 1, decode_o());
        tbl[13] = v(0, 5'b01100, 0, 0, 1, mk(E_PC | E_RF, 0, 2'd0, 0, 3'd4, 0, 1, 1));
        tbl[14] = v(0, 5'b10011, 0, 0, 1, fetch_rdy());
        tbl[15] = v(0, 5'b10011, 0, 0, 1, decode_o());
        tbl[16] = v(0, 5'b10011, 0, 0, 1, mk(E_ALUO | E_FLG, 1, 2'd1, 1, 3'd0, 0, 0, 0));

        reset = 1'b1; instr = '0; flag_z = 1'b0; flag_n = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) apply(tbl[i]);

        // LD with three MEM wait states, then ST with fetch waits
        gen_instr(5'b00100, 0, 0, 0, 3);
        gen_instr(5'b00101, 0, 0, 2, 1);
        run_queue();

        for (int k = 0; k < 60; k++) begin
            logic [4:0] ins;
            ins = rnd5();
            if (ins[3:0] == 4'd15) ins[3:0] = 4'd1;
            gen_instr(ins, rnd1(), rnd1(), $urandom_range(2, 0), $urandom_range(3, 0));
            run_queue();
        end

        // HALT holds with everything idle until a reset pulse
        gen_instr(5'b01111, 0, 0, 1, 0);
        for (int i = 0; i < 22; i++) push(0, rnd5(), rnd1(), rnd1(), rnd1(), mk(E_HLT, 0, 2'd0, 0, 3'd0, 0, 0, 0));
        push(1, rnd5(), 0, 0, 1, '0);
        push(0, rnd5(), 0, 0, 0, fetch_wait());
        push(0, rnd5(), 0, 0, 1, fetch_rdy());
        // ST abandoned by reset while waiting in MEM
        push(0, 5'b00101, 0, 0, 0, decode_o());
        push(0, 5'b00101, 0, 0, 0, mk(E_WR, 0, 2'd0, 0, 3'd0, 1, 0, 0));
        push(0, 5'b00101, 0, 0, 0, mk(E_WR, 0, 2'd0, 0, 3'd0, 1, 0, 0));
        push(1, 5'b00101, 0, 0, 0, '0);
        push(1, 5'b00101, 0, 0, 1, '0);
        push(0, 5'b00101, 0, 0, 0, fetch_wait());
        push(0, 5'b00101, 0, 0, 1, fetch_rdy());
        push(0, 5'b00000, 0, 0, 1, decode_o());
        push(0, 5'b10000, 0, 0, 1, mk(E_RF, 0, 2'd0, 0, 3'd3, 0, 0, 0));
        run_queue();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
